// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Funct encodings, FSM states and iteration count.
package muldiv_unit_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam int MD_ITERS = 32;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } md_state_t;

endpackage

// File: rtl/md_addsub.sv
// Shared adder/subtractor for multiply accumulate and divide trial.
// cout is the no-borrow flag when subtracting.
module md_addsub #(
  parameter int N = 33
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         sub,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N-1:0] yEff;

  assign yEff = sub ? ~y : y;
  assign {cout, sum} = {1'b0, x}
                     + {1'b0, yEff}
                     + {{N{1'b0}}, sub};

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO.
// Shift-add multiply and restoring divide on magnitudes.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mdstart,
  input  logic             hilosrc,
  input  logic             hilosel,
  input  logic [1:0]       funct,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             mdrun,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W  = WIDTH;
  localparam int CW = $clog2(MD_ITERS);
  localparam logic [CW-1:0] LAST =
    CW'(MD_ITERS - 1);

  md_state_t      state;
  logic [CW-1:0]  cnt;
  logic [1:0]     op;
  logic [W-1:0]   opr;
  logic [W-1:0]   rawA;
  logic [2*W-1:0] acc;
  logic           negRes;
  logic           negRem;

  logic           sgnIn;
  logic           divIn;
  logic           isDiv;
  logic [W-1:0]   magA;
  logic [W-1:0]   magB;

  logic [W:0]     asX;
  logic [W:0]     asY;
  logic [W:0]     asSum;
  logic           asCout;

  logic [2*W-1:0] accNext;
  logic [2*W-1:0] prod;
  logic [W-1:0]   quo;
  logic [W-1:0]   rem;
  logic [W-1:0]   hiFix;
  logic [W-1:0]   loFix;

  assign mdrun = (state != IDLE);

  assign sgnIn = (funct == MD_MULT) ||
                 (funct == MD_DIV);
  assign divIn = (funct == MD_DIV) ||
                 (funct == MD_DIVU);
  assign isDiv = (op == MD_DIV) ||
                 (op == MD_DIVU);

  assign magA = (sgnIn && a[W-1]) ? -a : a;
  assign magB = (sgnIn && b[W-1]) ? -b : b;

  // Divide trials {rem,quo} shifted left; multiply adds to upper half.
  assign asX = isDiv ? acc[2*W-1:W-1]
                     : {1'b0, acc[2*W-1:W]};
  assign asY = {1'b0, opr};

  md_addsub #(
    .N(W + 1)
  ) u_addsub (
    .x   (asX),
    .y   (asY),
    .sub (isDiv),
    .sum (asSum),
    .cout(asCout)
  );

  always_comb begin
    accNext = acc;
    unique case (1'b1)
      isDiv && asCout:
        accNext = {asSum[W-1:0],
                   acc[W-2:0], 1'b1};
      isDiv && !asCout:
        accNext = {acc[2*W-2:0], 1'b0};
      !isDiv && acc[0]:
        accNext = {asSum, acc[W-1:1]};
      default:
        accNext = {1'b0, acc[2*W-1:1]};
    endcase
  end

  always_comb begin
    prod  = negRes ? -acc : acc;
    quo   = acc[W-1:0];
    rem   = acc[2*W-1:W];
    hiFix = prod[2*W-1:W];
    loFix = prod[W-1:0];
    if (isDiv) begin
      if (opr == '0) begin
        loFix = '1;
        hiFix = rawA;
      end else begin
        loFix = negRes ? -quo : quo;
        hiFix = negRem ? -rem : rem;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      op     <= MD_MULT;
      opr    <= '0;
      rawA   <= '0;
      acc    <= '0;
      negRes <= 1'b0;
      negRem <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (mdstart && hilosrc) begin
            if (hilosel) hi <= a;
            else         lo <= a;
          end else if (mdstart) begin
            op     <= funct;
            rawA   <= a;
            cnt    <= '0;
            negRes <= sgnIn & (a[W-1] ^ b[W-1]);
            negRem <= sgnIn & a[W-1];
            if (divIn) begin
              opr <= magB;
              acc <= {{W{1'b0}}, magA};
            end else begin
              opr <= magA;
              acc <= {{W{1'b0}}, magB};
            end
            state <= CALC;
          end
        end
        CALC: begin
          acc <= accNext;
          if (cnt == LAST) state <= FIX;
          else             cnt <= cnt + 1'b1;
        end
        FIX: begin
          hi    <= hiFix;
          lo    <= loFix;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit.
// Arithmetic reference model plus per-cycle output compare.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mdstart;
  logic        hilosrc;
  logic        hilosel;
  logic [1:0]  funct;
  logic        flush;
  logic [31:0] a;
  logic [31:0] b;
  logic        mdrun;
  logic [31:0] hi;
  logic [31:0] lo;

  int nChecks = 0;
  int nFails  = 0;
  bit chkEn   = 1'b0;

  logic [31:0] mHi = '0;
  logic [31:0] mLo = '0;
  logic [31:0] pHi = '0;
  logic [31:0] pLo = '0;
  int          mBusy = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .mdstart(mdstart),
    .hilosrc(hilosrc),
    .hilosel(hilosel),
    .funct  (funct),
    .flush  (flush),
    .a      (a),
    .b      (b),
    .mdrun  (mdrun),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  // Architectural result from plain integer arithmetic.
  function automatic void refOp(input logic [1:0] f,
                                input logic [31:0] x,
                                input logic [31:0] y,
                                output logic [31:0] h,
                                output logic [31:0] l);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p  = '0;
    case (f)
      2'b00: p = sx * sy;
      2'b01: p = {32'b0, x} * {32'b0, y};
      default: begin
        if (y == 0) begin
          p = {x, 32'hFFFF_FFFF};
        end else if (f == 2'b10) begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end else begin
          p = {x % y, x / y};
        end
      end
    endcase
    h = p[63:32];
    l = p[31:0];
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mBusy = 0;
      mHi   = '0;
      mLo   = '0;
    end else if (flush) begin
      mBusy = 0;
    end else if (mBusy > 0) begin
      mBusy--;
      if (mBusy == 0) begin
        mHi = pHi;
        mLo = pLo;
      end
    end else if (mdstart) begin
      if (hilosrc) begin
        if (hilosel) mHi = a;
        else         mLo = a;
      end else begin
        refOp(funct, a, b, pHi, pLo);
        mBusy = 33;
      end
    end
  end

  always @(negedge clk) begin
    if (chkEn) begin
      chk("mdrun", 64'(mdrun), 64'(mBusy != 0));
      chk("hi", 64'(hi), 64'(mHi));
      chk("lo", 64'(lo), 64'(mLo));
    end
  end

  task automatic run(input logic [1:0] f,
                     input logic [31:0] av,
                     input logic [31:0] bv,
                     input int flushAt,
                     input int poke,
                     output int n);
    bit done;
    @(negedge clk);
    mdstart = 1'b1;
    hilosrc = 1'b0;
    funct   = f;
    a       = av;
    b       = bv;
    n    = 0;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      mdstart = 1'b0;
      flush   = 1'b0;
      if (!mdrun) begin
        done = 1'b1;
      end else begin
        n++;
        if (n == flushAt) flush = 1'b1;
        if (n == poke) begin
          mdstart = 1'b1;
          hilosrc = 1'($urandom_range(0, 1));
          funct   = 2'($urandom_range(0, 3));
          a       = $urandom;
          b       = $urandom;
        end
      end
    end
    chk("run_done", 64'(done), 64'd1);
  endtask

  task automatic moveTo(input logic sel,
                        input logic [31:0] v);
    @(negedge clk);
    mdstart = 1'b1;
    hilosrc = 1'b1;
    hilosel = sel;
    a       = v;
    @(negedge clk);
    mdstart = 1'b0;
    hilosrc = 1'b0;
  endtask

  task automatic expHL(input string nm,
                       input logic [31:0] eh,
                       input logic [31:0] el);
    chk({nm, "_hi"}, 64'(hi), 64'(eh));
    chk({nm, "_lo"}, 64'(lo), 64'(el));
  endtask

  function automatic logic [31:0] pick();
    int s;
    s = $urandom_range(0, 9);
    case (s)
      0: pick = 32'h0;
      1: pick = 32'h8000_0000;
      2: pick = 32'hFFFF_FFFF;
      3: pick = 32'(s);
      default: pick = $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    int fa, pk;
    logic [1:0]  rf;
    logic [31:0] ra, rb;

    reset   = 1'b1;
    mdstart = 1'b0;
    hilosrc = 1'b0;
    hilosel = 1'b0;
    funct   = 2'b00;
    flush   = 1'b0;
    a       = '0;
    b       = '0;
    #2 reset = 1'b0;
    #1;
    chk("rst_mdrun", 64'(mdrun), 64'd0);
    expHL("rst", 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chkEn = 1'b1;

    run(2'b00, 32'hFFFF_FFFD, 32'd5, 0, 0, n);
    chk("mult_busy", 64'(n), 64'd33);
    expHL("mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1);

    run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, n);
    expHL("multu", 32'hFFFF_FFFE, 32'h0000_0001);

    run(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0, n);
    expHL("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    run(2'b11, 32'd100, 32'd7, 0, 0, n);
    expHL("divu", 32'd2, 32'd14);

    run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, n);
    expHL("div_ovf", 32'h0, 32'h8000_0000);

    run(2'b11, 32'h1234, 32'h0, 0, 0, n);
    chk("divz_busy", 64'(n), 64'd33);
    expHL("divu_z", 32'h1234, 32'hFFFF_FFFF);

    run(2'b10, 32'hFFFF_FFF9, 32'h0, 0, 0, n);
    expHL("div_z", 32'hFFFF_FFF9, 32'hFFFF_FFFF);

    moveTo(1'b1, 32'hAA);
    moveTo(1'b0, 32'hBB);
    expHL("mt", 32'hAA, 32'hBB);
    run(2'b00, 32'd3, 32'd4, 10, 0, n);
    chk("flush_n", 64'(n), 64'd10);
    chk("flush_run", 64'(mdrun), 64'd0);
    expHL("flush", 32'hAA, 32'hBB);

    run(2'b00, 32'd3, 32'd4, 0, 7, n);
    chk("poke_busy", 64'(n), 64'd33);
    expHL("poke", 32'h0, 32'd12);

    @(negedge clk);
    mdstart = 1'b1;
    hilosrc = 1'b0;
    funct   = 2'b11;
    a       = 32'd1000;
    b       = 32'd3;
    @(negedge clk);
    mdstart = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_mdrun", 64'(mdrun), 64'd0);
    expHL("arst", 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    moveTo(1'b0, 32'h55);
    chk("mtlo_run", 64'(mdrun), 64'd0);
    chk("mtlo", 64'(lo), 64'h55);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0)
        moveTo(1'($urandom_range(0, 1)), $urandom);
      rf = 2'($urandom_range(0, 3));
      ra = pick();
      rb = pick();
      fa = ($urandom_range(0, 5) == 0) ?
           int'($urandom_range(1, 33)) : 0;
      pk = int'($urandom_range(1, 45));
      run(rf, ra, rb, fa, pk, n);
      if (fa == 0)
        chk("rnd_busy", 64'(n), 64'd33);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
